// File: rtl/fwuart_rx_fifo.sv
// Receive FIFO behind fwuart_rx: show-ahead ready/valid buffer with fill level,
// threshold flag, sticky overrun and a 16550-style character timeout.
module fwuart_rx_fifo #(
    parameter int DEPTH         = 16,
    parameter int THRESH        = 8,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clock_x16,
    input  logic [7:0]                 i_dat,
    input  logic                       i_valid,
    output logic                       i_ready,
    output logic [7:0]                 o_dat,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       thresh_irq,
    output logic                       timeout_irq,
    output logic                       overrun,
    input  logic                       clr_overrun
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int LIMIT = TIMEOUT_CHARS * 160;
    localparam int CW    = $clog2(LIMIT + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, thresh_q, tmo_q, ovr_q, ovr_d, started_q;
    logic          wr, rd;

    assign wr = i_valid & ready_q;
    assign rd = o_valid & o_ready;

    always_comb begin
        level_d = level_q;
        if (wr && !rd) begin
            level_d = level_q + LW'(1);
        end else if (rd && !wr) begin
            level_d = level_q - LW'(1);
        end
    end

    // Counter only runs while data sits untouched in the FIFO.
    always_comb begin
        cnt_d = cnt_q;
        if (wr || rd || level_q == '0) begin
            cnt_d = '0;
        end else if (clock_x16 && cnt_q != CW'(LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A refused byte during the first post-reset cycle is not an overrun.
    always_comb begin
        ovr_d = ovr_q;
        if (i_valid && !ready_q && started_q) begin
            ovr_d = 1'b1;
        end else if (clr_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= i_dat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            thresh_q  <= 1'b0;
            tmo_q     <= 1'b0;
            ovr_q     <= 1'b0;
            started_q <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            ready_q   <= (level_d != LW'(DEPTH));
            thresh_q  <= (level_d >= LW'(THRESH));
            tmo_q     <= (cnt_d == CW'(LIMIT));
            ovr_q     <= ovr_d;
            started_q <= 1'b1;
        end
    end

    assign i_ready     = ready_q;
    assign o_valid     = (level_q != '0);
    assign o_dat       = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign thresh_irq  = thresh_q;
    assign timeout_irq = tmo_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_fwuart_rx_fifo.sv
// Directed self-checking bench for fwuart_rx_fifo (DEPTH=16, THRESH=8,
// TIMEOUT_CHARS=4).
module tb_fwuart_rx_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clock_x16 = 1'b0;
    logic [7:0] i_dat = 8'h00;
    logic       i_valid = 1'b0;
    logic       i_ready;
    logic [7:0] o_dat;
    logic       o_valid;
    logic       o_ready = 1'b0;
    logic [4:0] level;
    logic       thresh_irq;
    logic       timeout_irq;
    logic       overrun;
    logic       clr_overrun = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    fwuart_rx_fifo #(
        .DEPTH(16),
        .THRESH(8),
        .TIMEOUT_CHARS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clock_x16(clock_x16),
        .i_dat(i_dat),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .o_dat(o_dat),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .level(level),
        .thresh_irq(thresh_irq),
        .timeout_irq(timeout_irq),
        .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        // reset values
        #12;
        chk("rst_level", 32'(level), 0);
        chk("rst_ovalid", 32'(o_valid), 0);
        chk("rst_iready", 32'(i_ready), 0);
        chk("rst_thresh", 32'(thresh_irq), 0);
        chk("rst_tmo", 32'(timeout_irq), 0);
        chk("rst_ovr", 32'(overrun), 0);
        step(1);
        reset = 1'b1;
        chk("rel_iready0", 32'(i_ready), 0);
        step(1);
        chk("rel_iready1", 32'(i_ready), 1);

        // 1: pass-through with o_ready high
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_dat   = 8'h55;
        step(1);
        chk("t1_v0", 32'(o_valid), 1);
        chk("t1_d0", 32'(o_dat), 32'h55);
        chk("t1_l0", 32'(level), 1);
        i_dat = 8'hAA;
        step(1);
        chk("t1_d1", 32'(o_dat), 32'hAA);
        chk("t1_l1", 32'(level), 1);
        i_dat = 8'h01;
        step(1);
        chk("t1_d2", 32'(o_dat), 32'h01);
        i_valid = 1'b0;
        step(1);
        chk("t1_lend", 32'(level), 0);
        chk("t1_vend", 32'(o_valid), 0);

        // 2: fill to full, threshold, overrun, drain
        o_ready = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i_dat = 8'(k);
            step(1);
            if (k == 6) chk("t2_thr7", 32'(thresh_irq), 0);
            if (k == 7) chk("t2_thr8", 32'(thresh_irq), 1);
            if (k == 14) chk("t2_rdy15", 32'(i_ready), 1);
        end
        chk("t2_rdy16", 32'(i_ready), 0);
        chk("t2_l16", 32'(level), 16);
        i_dat = 8'h10;
        step(1);
        chk("t2_ovr", 32'(overrun), 1);
        chk("t2_l16b", 32'(level), 16);
        o_ready = 1'b1;
        for (int j = 0; j < 17; j++) begin
            chk("t2_dv", 32'(o_valid), 1);
            chk("t2_dat", 32'(o_dat), (j < 16) ? j : 32'h10);
            step(1);
            if (j == 0) chk("t3_full_rw", 32'(level), 15);
            if (j == 1) begin
                chk("t2_acc10", 32'(level), 15);
                i_valid = 1'b0;
            end
        end
        chk("t2_lend", 32'(level), 0);
        chk("t2_thr_end", 32'(thresh_irq), 0);

        // 3: simultaneous read+write at level 5
        o_ready = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_dat = 8'h20 + 8'(k);
            step(1);
        end
        chk("t3_l5", 32'(level), 5);
        i_dat   = 8'h25;
        o_ready = 1'b1;
        step(1);
        chk("t3_l5rw", 32'(level), 5);
        chk("t3_head", 32'(o_dat), 32'h21);
        o_ready = 1'b0;

        // 6: clr_overrun against a refused write
        for (int k = 0; k < 11; k++) begin
            i_dat = 8'h30 + 8'(k);
            step(1);
        end
        chk("t6_full", 32'(level), 16);
        i_valid     = 1'b0;
        clr_overrun = 1'b1;
        step(1);
        chk("t6_clr", 32'(overrun), 0);
        i_valid = 1'b1;
        step(1);
        chk("t6_setwins", 32'(overrun), 1);
        i_valid     = 1'b0;
        clr_overrun = 1'b0;

        // 5: asynchronous reset at level 5
        o_ready = 1'b1;
        step(11);
        o_ready = 1'b0;
        step(1);
        chk("t5_l5", 32'(level), 5);
        chk("t5_ovr1", 32'(overrun), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_level", 32'(level), 0);
        chk("t5_ovalid", 32'(o_valid), 0);
        chk("t5_ovr0", 32'(overrun), 0);
        chk("t5_rdy0", 32'(i_ready), 0);
        #2;
        reset = 1'b1;
        step(1);
        chk("t5_rdy1", 32'(i_ready), 1);

        // 4: character timeout
        i_valid = 1'b1;
        i_dat   = 8'h77;
        step(1);
        i_valid = 1'b0;
        for (int t = 1; t <= 640; t++) begin
            clock_x16 = 1'b1;
            step(1);
            clock_x16 = 1'b0;
            if (t == 1) chk("t4_tick1", 32'(timeout_irq), 0);
            if (t == 639) chk("t4_tick639", 32'(timeout_irq), 0);
            if (t == 640) chk("t4_tick640", 32'(timeout_irq), 1);
            step(1);
        end
        chk("t4_hold", 32'(timeout_irq), 1);
        chk("t4_dat", 32'(o_dat), 32'h77);
        o_ready = 1'b1;
        step(1);
        o_ready = 1'b0;
        chk("t4_clr", 32'(timeout_irq), 0);
        chk("t4_empty", 32'(level), 0);
        chk("t4_ovalid", 32'(o_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
